dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter giving four cores shared access to a
// single-port 16-bit data memory, one transaction per three cycles.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req, we    per-core request and write enable (bit i = core i)
//   addr       per-core 16-bit word address, core i at [16i+15:16i]
//   wdata      per-core 16-bit write data, same slicing as addr
//   rdata      response data, meaningful while ack is non-zero
//   ack        one-hot, single-cycle completion strobe
//   err        pulses with ack when the served address was out of range
//   busy       transaction in flight (ACCESS or RESP)
//   grant_id   index of the core currently or last served
module dm_arbiter #(
    parameter int DEPTH  = 256,
    parameter int NCORES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCORES-1:0]     req,
    input  logic [NCORES-1:0]     we,
    input  logic [16*NCORES-1:0]  addr,
    input  logic [16*NCORES-1:0]  wdata,
    output logic [15:0]           rdata,
    output logic [NCORES-1:0]     ack,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            grant_id
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  last_grant;
    logic [1:0]  pick;
    logic        found;

    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        in_range;
    logic [AW-1:0] idx;

    logic [15:0] mem [DEPTH];

    assign in_range = (lat_addr[15:AW] == '0);
    assign idx      = lat_addr[AW-1:0];

    // Search starts one past the last grant; i == NCORES wraps back onto
    // last_grant itself, so a lone repeat requester is still served.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int i = 1; i <= NCORES; i++) begin
            if (!found && req[last_grant + 2'(i)]) begin
                pick  = last_grant + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack  = '0;
        err  = 1'b0;
        busy = (state != IDLE);
        if (state == RESP) begin
            ack[grant_id] = 1'b1;
            err           = !in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
            lat_we     <= 1'b0;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
            rdata      <= 16'h0000;
        end else if (state == IDLE) begin
            if (|req) begin
                grant_id  <= pick;
                lat_we    <= we[pick];
                lat_addr  <= addr[{pick, 4'h0} +: 16];
                lat_wdata <= wdata[{pick, 4'h0} +: 16];
            end
        end else if (state == ACCESS) begin
            if (!in_range) begin
                rdata <= 16'h0000;
            end else if (lat_we) begin
                rdata <= lat_wdata;
            end else begin
                rdata <= mem[idx];
            end
        end else if (state == RESP) begin
            last_grant <= grant_id;
        end
    end

    // Memory has no reset; the rst gate stops a write racing an abort.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && lat_we && in_range) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule
